// File: rtl/wb_scheduler.sv
// Writeback-port scheduler: EX owns reserved slots, MEM and ALU share the rest with
// ALU anti-starvation; the winning write is registered onto the register-file port.
package params_pkg;
    localparam int REGISTER_WIDTH = 5;
endpackage

module wb_scheduler #(
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
    parameter int DATA_WIDTH     = 32,
    parameter int MUL_LATENCY    = 5,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ex_issue_i,
    input  logic                      ex_wb_valid_i,
    input  logic [REGISTER_WIDTH-1:0] ex_wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     ex_wb_data_i,
    input  logic                      mem_req_i,
    input  logic [REGISTER_WIDTH-1:0] mem_rd_i,
    input  logic [DATA_WIDTH-1:0]     mem_data_i,
    output logic                      mem_gnt_o,
    input  logic                      alu_req_i,
    input  logic [REGISTER_WIDTH-1:0] alu_rd_i,
    input  logic [DATA_WIDTH-1:0]     alu_data_i,
    output logic                      alu_gnt_o,
    output logic                      wb_is_next_cycle_o,
    output logic                      rf_we_o,
    output logic [REGISTER_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0]     rf_wdata_o,
    output logic                      wb_err_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [MUL_LATENCY-1:0]    res_q, res_d;
    logic [SW-1:0]             starve_q, starve_d;
    logic                      boot_q;
    logic                      rf_we_q, rf_we_d;
    logic [REGISTER_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0]     rf_wdata_q, rf_wdata_d;
    logic                      wb_err_q, wb_err_d;

    logic ex_own;
    logic alu_prio;
    logic mem_gnt;
    logic alu_gnt;

    always_comb begin
        res_d = {ex_issue_i, res_q[MUL_LATENCY-1:1]};

        // A writeback without a reservation still owns the slot so the result is not lost.
        ex_own   = res_q[0] | ex_wb_valid_i;
        alu_prio = alu_req_i && (starve_q == STARVE_MAX);
        mem_gnt  = !boot_q && !ex_own && mem_req_i && !alu_prio;
        alu_gnt  = !boot_q && !ex_own && alu_req_i && (alu_prio || !mem_req_i);

        starve_d = starve_q;
        if (alu_gnt || !alu_req_i) begin
            starve_d = '0;
        end else if (mem_gnt && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end

        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (ex_own) begin
            if (ex_wb_valid_i) begin
                rf_we_d    = (ex_wb_rd_i != '0);
                rf_waddr_d = ex_wb_rd_i;
                rf_wdata_d = ex_wb_data_i;
            end
        end else if (mem_gnt) begin
            rf_we_d    = (mem_rd_i != '0);
            rf_waddr_d = mem_rd_i;
            rf_wdata_d = mem_data_i;
        end else if (alu_gnt) begin
            rf_we_d    = (alu_rd_i != '0);
            rf_waddr_d = alu_rd_i;
            rf_wdata_d = alu_data_i;
        end

        wb_err_d = wb_err_q | (ex_wb_valid_i != res_q[0]);
    end

    // boot_q blocks MEM/ALU grants for the single cycle following reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_q      <= '0;
            starve_q   <= '0;
            boot_q     <= 1'b1;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            res_q      <= res_d;
            starve_q   <= starve_d;
            boot_q     <= 1'b0;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign mem_gnt_o          = mem_gnt;
    assign alu_gnt_o          = alu_gnt;
    assign wb_is_next_cycle_o = res_q[1];
    assign rf_we_o            = rf_we_q;
    assign rf_waddr_o         = rf_waddr_q;
    assign rf_wdata_o         = rf_wdata_q;
    assign wb_err_o           = wb_err_q;

endmodule
